// File: rtl/seg_bcd_fmt.sv
// -----------------------------------------------------------------------------
// seg_bcd_fmt
//   Converts two 10-bit unsigned amounts into six 4-bit display digit codes.
//   Each value pair is converted serially with shift-and-add-3 (double
//   dabble). The left operand is converted first, then the right one, and
//   both results are published together as one atomic update.
//
//   Digit codes: 0-9 = decimal digit, 4'hF = blank, 4'hE = dash.
//   A value above 999 is shown as three dashes.
//
// Parameters
//   BLANK_LZ  1 = blank leading zeros (units never blanked), 0 = show all.
//
// Ports
//   clk1k     in   1   clock (1 kHz tick domain)
//   clr       in   1   asynchronous reset, active low
//   in_valid  in   1   val_l / val_r are valid this cycle
//   in_ready  out  1   idle, a value pair can be accepted
//   val_l     in  10   left amount, binary unsigned
//   val_r     in  10   right amount, binary unsigned
//   seg       out 24   {L hund, L tens, L units, R hund, R tens, R units}
//   seg_vld   out  1   one-cycle pulse when seg takes a new value
// -----------------------------------------------------------------------------
module seg_bcd_fmt #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk1k,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  val_l,
  input  logic [9:0]  val_r,
  output logic [23:0] seg,
  output logic        seg_vld
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_L = 2'd1,
    SHIFT_R = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  localparam logic [23:0] SEG_RESET = 24'hFF0FF0;  // "  0  0"

  state_t      state, state_nxt;
  logic [9:0]  op_l, op_r;      // operands, shifted left one bit per iteration
  logic        ovf_l, ovf_r;    // operand above 999, shown as dashes
  logic [3:0]  cnt;             // iteration index within one operand
  logic [11:0] bcd_l, bcd_r;    // BCD accumulators
  logic        last_iter;

  assign last_iter = (cnt == 4'd9);
  assign in_ready  = (state == IDLE);

  // One double-dabble step: correct every nibble >= 5, then shift in a bit.
  function automatic logic [11:0] dabble(input logic [11:0] bcd,
                                         input logic        bit_in);
    logic [11:0] t;
    t = bcd;
    for (int i = 0; i < 3; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[10:0], bit_in};
  endfunction

  // Map a converted value to three display codes (dash / blanking rules).
  // An out-of-range operand overflows the 12-bit accumulator, so its BCD
  // result is meaningless and is replaced wholesale by dashes.
  function automatic logic [11:0] fmt(input logic [11:0] bcd,
                                      input logic        ovf);
    logic [3:0] h, t, u;
    h = bcd[11:8];
    t = bcd[7:4];
    u = bcd[3:0];
    if (BLANK_LZ && h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
    return ovf ? 12'hEEE : {h, t, u};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk1k or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT_L;
      SHIFT_L: if (last_iter) state_nxt = SHIFT_R;
      SHIFT_R: if (last_iter) state_nxt = UPDATE;
      UPDATE:                 state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so an abort leaves no stale
  // operand, count or partial BCD behind and seg returns to its idle pattern.
  always_ff @(posedge clk1k or negedge clr) begin
    if (!clr) begin
      op_l    <= '0;
      op_r    <= '0;
      ovf_l   <= 1'b0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
      bcd_l   <= '0;
      bcd_r   <= '0;
      seg     <= SEG_RESET;
      seg_vld <= 1'b0;
    end else begin
      seg_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_l  <= val_l;
            op_r  <= val_r;
            ovf_l <= (val_l > 10'd999);
            ovf_r <= (val_r > 10'd999);
            cnt   <= '0;
            bcd_l <= '0;
            bcd_r <= '0;
          end
        end
        SHIFT_L: begin
          bcd_l <= dabble(bcd_l, op_l[9]);
          op_l  <= {op_l[8:0], 1'b0};
          cnt   <= last_iter ? 4'd0 : cnt + 4'd1;
        end
        SHIFT_R: begin
          bcd_r <= dabble(bcd_r, op_r[9]);
          op_r  <= {op_r[8:0], 1'b0};
          cnt   <= last_iter ? 4'd0 : cnt + 4'd1;
        end
        UPDATE: begin
          seg     <= {fmt(bcd_l, ovf_l), fmt(bcd_r, ovf_r)};
          seg_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seg_bcd_fmt.md
SEG_BCD_FMT -- requirements
Module: seg_bcd_fmt

Interface
REQ-001 Parameter BLANK_LZ, default 1, meaning: 1 = blank leading zeros, 0 = show all digits.
REQ-002 clk1k  input  1  system clock, 1 kHz tick domain.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  val_l/val_r are valid this cycle.
REQ-005 in_ready  output  1  block is idle and can accept a value pair.
REQ-006 val_l  input  10  left amount, binary, unsigned.
REQ-007 val_r  input  10  right amount, binary, unsigned.
REQ-008 seg  output  24  six 4-bit digit codes for the display driver.
REQ-009 seg_vld  output  1  one-cycle pulse when seg takes a new value.

Function
REQ-010 Digit layout SHALL be seg[23:20]/[19:16]/[15:12] = left hundreds/tens/units and seg[11:8]/[7:4]/[3:0] = right hundreds/tens/units.
REQ-011 Digit codes SHALL be 0-9 for decimal digits, 4'hF for blank, and 4'hE for dash.
REQ-012 The FSM SHALL have four states: IDLE, SHIFT_L, SHIFT_R and UPDATE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 Accept edge E0 SHALL be the rising edge where in_valid=1 and in_ready=1; at E0 the block captures val_l and val_r, clears both BCD accumulators and moves to SHIFT_L.
REQ-015 in_valid outside IDLE SHALL be ignored; operands are not captured and state does not change.
REQ-016 Conversion SHALL be shift-and-add-3 (double dabble), one bit per clock, MSB first: each nibble >=5 gets +3, then the 12-bit BCD register shifts left by 1 with the next binary bit.
REQ-017 SHIFT_L SHALL run exactly 10 iterations on edges E1..E10 and then move to SHIFT_R.
REQ-018 SHIFT_R SHALL run exactly 10 iterations on edges E11..E20 and then move to UPDATE.
REQ-019 At E21 the block SHALL register seg, assert seg_vld for exactly one cycle and return to IDLE, so latency from accept to seg update is 21 edges.
REQ-020 An operand >999 SHALL be flagged at E0, and its three digits SHALL be forced to E,E,E at E21 regardless of the BCD result.
REQ-021 With BLANK_LZ=1, hundreds SHALL be blank if hundreds=0; tens SHALL be blank if hundreds=0 and tens=0; units are never blanked, so value 0 shows as F,F,0.
REQ-022 With BLANK_LZ=0, all digits SHALL be shown and no blank code is produced for in-range values.
REQ-023 seg SHALL change only at E21, atomically on all 24 bits, and SHALL hold its value between updates.
REQ-024 An accept at the same edge the block returns to IDLE SHALL NOT occur, because in_ready is 0 during UPDATE; the earliest next accept is E22.
REQ-025 seg_vld SHALL be 0 in every cycle except the one following E21.

Reset
REQ-026 While clr=0: state SHALL be IDLE, in_ready=1, seg_vld=0, seg=24'hFF0FF0 (shows "  0  0"), and operand, counter and accumulator registers SHALL be 0.
REQ-027 clr asserted mid-conversion SHALL abort it immediately, with no seg_vld pulse and seg at its reset value.
REQ-028 After clr deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-029 Send val_l=123, val_r=45 with BLANK_LZ=1 -> at E21 seg=24'h123F45, seg_vld high for 1 cycle, in_ready low on E1..E21.
REQ-030 Send val_l=0, val_r=999 with BLANK_LZ=1 -> seg=24'hFF0999; repeat with BLANK_LZ=0 and val_l=7 -> seg=24'h007999.
REQ-031 Send val_l=1000, val_r=1023 -> seg=24'hEEEEEE; send val_l=1023, val_r=5 -> seg=24'hEEEFF5.
REQ-032 Pulse in_valid with new operands during SHIFT_R -> ignored; seg reflects only the first pair, and a second pair presented at E22 is accepted with its result at E22+21.
REQ-033 Assert clr at E15 of a conversion -> seg=24'hFF0FF0 immediately, no seg_vld pulse; after release, accepting 250/8 -> seg=24'h250FF8.
REQ-034 Sweep all 1024 values on both sides with BLANK_LZ=1 and BLANK_LZ=0 -> every seg matches the reference decimal model, including blanking and dash rules.
